// File: rtl/regfile_pkg.sv
// Shared types for the parametrised register file: clear/run state and depth derivation.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, then opens the register file for traffic.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready,
  output state_t            state
);

  logic [ADDR_W-1:0] clr_ptr;

  // The pointer holds at the last entry rather than wrapping; RUN is terminal until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (clr_ptr == '1) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  assign clr_we   = (state == ST_CLEAR) && !reset;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_param.sv
// Two-read, one-write register file with hardwired zero, optional bypass and post-reset clear.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1_in,
  input  logic [ADDR_W-1:0] a2_in,
  input  logic [ADDR_W-1:0] a3_in,
  input  logic [DATA_W-1:0] wd3_in,
  input  logic              we3,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic              ready
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1_nxt;
  logic [DATA_W-1:0] rd2_nxt;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready),
    .state    (state)
  );

  assign run   = (state == ST_RUN);
  assign wr_ok = run && !reset && we3 && !((ZERO_REG != 0) && (a3_in == '0));

  // Reads see the pre-write array contents; the forwarded value only applies with BYPASS.
  always_comb begin
    rd1_nxt = mem[a1_in];
    rd2_nxt = mem[a2_in];
    if ((BYPASS != 0) && wr_ok && (a3_in == a1_in)) rd1_nxt = wd3_in;
    if ((BYPASS != 0) && wr_ok && (a3_in == a2_in)) rd2_nxt = wd3_in;
    if ((ZERO_REG != 0) && (a1_in == '0)) rd1_nxt = '0;
    if ((ZERO_REG != 0) && (a2_in == '0)) rd2_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[a3_in] <= wd3_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      rd1_out <= '0;
      rd2_out <= '0;
    end else begin
      rd1_out <= rd1_nxt;
      rd2_out <= rd2_nxt;
    end
  end

endmodule
